// File: rtl/retire_unit_pkg.sv
// Shared types for the retire stage: ROB entry layout, FSM state, sizing.
package retire_unit_pkg;

   localparam int EXT_COUNT    = 4;
   localparam int EXTCOUNTLOG2 = $clog2(EXT_COUNT);

   typedef struct packed {
      logic [31:0] result_lo;
      logic [4:0]  dest_reg;
      logic        dest_reg_valid;
      logic        is_store;
   } rob_entry_t;

   typedef enum logic {RUN = 1'b0, ST_WAIT = 1'b1} retire_state_t;

   // number of set bits in a slot mask
   function automatic logic [EXTCOUNTLOG2:0] popcnt(input logic [EXT_COUNT-1:0] v);
      logic [EXTCOUNTLOG2:0] n;
      n = '0;
      for (int i = 0; i < EXT_COUNT; i++) n = n + {{EXTCOUNTLOG2{1'b0}}, v[i]};
      return n;
   endfunction

endpackage

// File: rtl/retire_unit_if.sv
// ROB head extract / consume handshake between the reorder buffer and retire.
interface retire_unit_if;
   import retire_unit_pkg::*;

   rob_entry_t [EXT_COUNT-1:0]  slot_data;
   logic [EXT_COUNT-1:0]        slot_valid;
   logic [EXT_COUNT-1:0]        slot_kill;
   logic                        consume;
   logic [EXTCOUNTLOG2-1:0]     consume_count;

   modport master (output slot_data, slot_valid, slot_kill, input consume, consume_count);
   modport slave  (input slot_data, slot_valid, slot_kill, output consume, consume_count);
endinterface

// File: rtl/retire_select.sv
// Combinational retire selection: contiguous retirable prefix, its size,
// the non-killed part of it, and per-lane RF write enables with
// same-group WAW suppression (the youngest writer of a register wins).
module retire_select
   import retire_unit_pkg::*;
(
   input  rob_entry_t [EXT_COUNT-1:0] slot_data,
   input  logic [EXT_COUNT-1:0]       slot_valid,
   input  logic [EXT_COUNT-1:0]       slot_kill,
   output logic [EXT_COUNT-1:0]       we_mask,
   output logic [EXTCOUNTLOG2:0]      ret_n,
   output logic [EXTCOUNTLOG2:0]      live_n
);

   logic [EXT_COUNT-1:0] ret_mask;
   logic [EXT_COUNT-1:0] wr;
   logic                 chain;

   // retirable prefix; a live store breaks the chain (it commits via the LSU handshake)
   always_comb begin
      chain    = 1'b1;
      ret_mask = '0;
      for (int i = 0; i < EXT_COUNT; i++) begin
         chain       = chain && slot_valid[i] && !(slot_data[i].is_store && !slot_kill[i]);
         ret_mask[i] = chain;
      end
   end

   // raw writes, then drop any lane overwritten by a younger lane in the same group
   always_comb begin
      wr      = '0;
      we_mask = '0;
      for (int i = 0; i < EXT_COUNT; i++)
         wr[i] = ret_mask[i] && !slot_kill[i] && !slot_data[i].is_store &&
                 slot_data[i].dest_reg_valid && (slot_data[i].dest_reg != 5'd0);
      for (int i = 0; i < EXT_COUNT; i++) begin
         we_mask[i] = wr[i];
         for (int j = i + 1; j < EXT_COUNT; j++)
            if (wr[j] && (slot_data[j].dest_reg == slot_data[i].dest_reg)) we_mask[i] = 1'b0;
      end
   end

   assign ret_n  = popcnt(ret_mask);
   assign live_n = popcnt(ret_mask & ~slot_kill);

endmodule

// File: rtl/retire_unit.sv
// In-order retire stage below the ROB. Retires the longest completed prefix
// of the head slots each cycle, writes the RF one cycle later, and commits
// live stores one at a time through a req/ack handshake with the LSU.
// Optional build macro RETIRE_PERF_EN adds killed/store-wait/stall counters.
module retire_unit
   import retire_unit_pkg::*;
(
   input  logic                        clock,
   input  logic                        reset_n,
   retire_unit_if.slave                rob,
   input  logic                        hold,
   output logic [EXT_COUNT-1:0]        rf_we,
   output logic [EXT_COUNT-1:0][4:0]   rf_waddr,
   output logic [EXT_COUNT-1:0][31:0]  rf_wdata,
   output logic                        store_commit_req,
   input  logic                        store_commit_ack,
   output logic [31:0]                 retired_count
`ifdef RETIRE_PERF_EN
   ,
   output logic [31:0]                 killed_count,
   output logic [31:0]                 store_wait_cycles,
   output logic [31:0]                 stall_cycles
`endif
);

   retire_state_t          state;
   logic [EXT_COUNT-1:0]   we_mask;
   logic [EXTCOUNTLOG2:0]  ret_n, live_n;
   logic                   run_retire, store_ack, head_store, consume;

   retire_select u_sel (
      .slot_data  (rob.slot_data),
      .slot_valid (rob.slot_valid),
      .slot_kill  (rob.slot_kill),
      .we_mask    (we_mask),
      .ret_n      (ret_n),
      .live_n     (live_n)
   );

   // hold only gates RUN; an outstanding store always finishes on ack
   assign run_retire = (state == RUN) && !hold && (ret_n != '0);
   assign store_ack  = (state == ST_WAIT) && store_commit_req && store_commit_ack;
   assign head_store = rob.slot_valid[0] && !rob.slot_kill[0] && rob.slot_data[0].is_store;
   assign consume    = run_retire || store_ack;

   assign rob.consume       = consume;
   assign rob.consume_count = run_retire ? EXTCOUNTLOG2'(ret_n - 1'b1) : '0;

   // FSM: a live store at the head parks us in ST_WAIT with req raised until ack
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state            <= RUN;
         store_commit_req <= 1'b0;
      end else begin
         case (state)
            RUN: if (!hold && head_store) begin
               state            <= ST_WAIT;
               store_commit_req <= 1'b1;
            end
            ST_WAIT: if (store_ack) begin
               state            <= RUN;
               store_commit_req <= 1'b0;
            end
            default: begin
               state            <= RUN;
               store_commit_req <= 1'b0;
            end
         endcase
      end
   end

   // RF write port: one-cycle pulse per retired group, address/data captured with it
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rf_we    <= '0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= run_retire ? we_mask : '0;
         for (int i = 0; i < EXT_COUNT; i++)
            if (run_retire && we_mask[i]) begin
               rf_waddr[i] <= rob.slot_data[i].dest_reg;
               rf_wdata[i] <= rob.slot_data[i].result_lo;
            end
      end
   end

   // retired instruction count (non-killed only), wraps at 2^32
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)        retired_count <= '0;
      else if (run_retire) retired_count <= retired_count + 32'(live_n);
      else if (store_ack)  retired_count <= retired_count + 32'd1;
   end

`ifdef RETIRE_PERF_EN
   // performance counters, all free-running and wrapping
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         killed_count      <= '0;
         store_wait_cycles <= '0;
         stall_cycles      <= '0;
      end else begin
         if (run_retire)                       killed_count      <= killed_count + 32'(ret_n - live_n);
         if (state == ST_WAIT)                 store_wait_cycles <= store_wait_cycles + 32'd1;
         if (rob.slot_valid[0] && !consume)    stall_cycles      <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: doc/retire_unit.md
Name: retire_unit

Overview:
- In-order commit stage directly downstream of the reorder buffer.
- Each cycle it inspects up to EXT_COUNT head slots and retires the longest contiguous prefix of completed entries.
- Retiring means: drive consume/consume_count back to the ROB, write results to the architectural register file, and drop killed (flushed) entries without side effects.
- Non-killed stores are committed one at a time through a request/acknowledge handshake with the load/store unit.

Parameters:
- EXT_COUNT, 4, head slots inspected per cycle; equals the ROB extract width.
- EXTCOUNTLOG2, $clog2(EXT_COUNT), width of consume_count.
- T, rob_entry_t, ROB entry type; fields used: result_lo[31:0], dest_reg[4:0], dest_reg_valid, is_store.

Ports:
- clock  in  1  single clock; all state on posedge.
- reset_n  in  1  asynchronous active-low reset.
- slot_data  in  T[EXT_COUNT]  head entries, slot 0 oldest.
- slot_valid  in  1[EXT_COUNT]  entry completed and present.
- slot_kill  in  1[EXT_COUNT]  entry flushed; consume without effect.
- consume  out  1  combinational; retire at this clock edge.
- consume_count  out  EXTCOUNTLOG2  number retired minus 1.
- hold  in  1  stall retirement (debug/trap drain).
- rf_we  out  1[EXT_COUNT]  registered register-file write enables.
- rf_waddr  out  5[EXT_COUNT]  registered write addresses.
- rf_wdata  out  32[EXT_COUNT]  registered write data.
- store_commit_req  out  1  registered; oldest store may write memory.
- store_commit_ack  in  1  LSU accepted store.
- retired_count  out  32  instructions retired, non-killed (see optional feature).

Behaviour:
- Reset (async, reset_n=0): FSM=RUN; rf_we all 0; rf_waddr/rf_wdata 0; store_commit_req 0; retired_count 0. Reset during ST_WAIT drops the pending request with no retire.
- FSM states: RUN, ST_WAIT.
- Retire mask in RUN (combinational), computed for i=0..EXT_COUNT-1. Slot i is retirable iff all of:
  - slot_valid[i];
  - all slots j<i are retirable;
  - not (is_store && !slot_kill[i]).
- Killed slots are always retirable when valid, stores included.
- N = number of retirable slots. consume = (N>0) && !hold && state==RUN; consume_count = N-1 (encoding matches the ROB's count+1 convention).
- RUN -> ST_WAIT when !hold, slot_valid[0], !slot_kill[0] and slot_data[0].is_store. Next cycle store_commit_req=1. consume=0 on the transition cycle.
- ST_WAIT: req held 1 until ack sampled 1.
  - On the ack cycle: consume=1, consume_count=0, retired_count+=1, next state RUN, req cleared next edge.
  - Ack while req=0 is ignored.
  - hold ignored in ST_WAIT.
- Register writes: for retired slot i, write when !slot_kill[i] && dest_reg_valid && dest_reg!=0.
  - WAW within one group: if a later retired slot writes the same dest_reg, the earlier slot's rf_we is suppressed.
  - Outputs registered: visible one cycle after the consume edge, asserted for exactly one cycle. Stores never write the RF.
- retired_count increments by the number of retired non-killed slots; it wraps modulo 2^32.
- ROB empty (all slot_valid=0): consume=0, no writes.
- A partial group is allowed: a gap at slot k means slots ≥k wait.

Optional Feature:
- RETIRE_PERF_EN.
- Defined: adds a 32-bit killed_count output (killed slots consumed), a 32-bit store_wait_cycles output (cycles in ST_WAIT), and a stall_cycles output (cycles where slot_valid[0] && !consume). All reset to 0 and wrap.
- Undefined: these ports and counters are absent. retired_count remains in both builds.

Decomposition:
- pipTypes: is_store field added to rob_entry_t; retire_state_t enum {RUN, ST_WAIT}.
- One sub-module: retire_select. It is purely combinational and computes the retire mask, N, and the WAW-suppressed write enables from slot_valid/slot_kill/slot_data. The top module holds the FSM, output registers and counters.

Test Plan:
- Four valid ALU entries writing r1,r2,r3,r4 -> consume=1, consume_count=3; next cycle rf_we=1111 with addresses 1..4 and matching data; retired_count=4.
- slot_valid=1,1,0,1 -> consume_count=1; only r-writes of slots 0,1; slot 3 is retired in a later cycle once slot 2 completes.
- Slot0 store not killed, slot1 valid ALU -> consume=0, store_commit_req=1 next cycle; ack after 3 cycles -> consume_count=0 on the ack cycle, req=0 after, slot1 retires the following cycle.
- Slots 0..3 valid, slots 1..3 killed (one a store) -> consume_count=3; rf_we only for slot 0; retired_count+=1; killed_count+=3 with RETIRE_PERF_EN.
- Slots 0 and 2 both write r5 with data 0xA and 0xB -> only slot 2's lane writes r5=0xB; dest_reg 0 never written.
- Assert reset_n=0 while in ST_WAIT with req=1 -> req=0 immediately, FSM=RUN, counters 0; a late ack is ignored.
